// File: rtl/devctrl_pkg.sv
// Shared constants for the MMIO device controller: register map, TCON bits, seven-segment table.
package devctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OFF_W   = 5;
    localparam int unsigned DISP_W  = 17;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned DIGI_W  = 12;
    localparam int unsigned PRE_W   = 20;
    localparam int unsigned IDX_W   = 2;

    // Byte offsets inside the 32-byte register window
    localparam logic [OFF_W-1:0] OFF_TH      = 5'h00;
    localparam logic [OFF_W-1:0] OFF_TL      = 5'h04;
    localparam logic [OFF_W-1:0] OFF_TCON    = 5'h08;
    localparam logic [OFF_W-1:0] OFF_LED     = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_DISP    = 5'h10;
    localparam logic [OFF_W-1:0] OFF_SYSTICK = 5'h14;

    // TCON bit positions
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;

    // DISP enable bit position
    localparam int unsigned DISP_EN = 16;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg7
    import devctrl_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_c
);

    // Table lookup of the segment pattern
    assign o_seg_c = SEG7_LUT[i_hex];

endmodule

// File: rtl/mmio_device_ctrl.sv
// MMIO peripheral block: LED register, scanned 4-digit display, interval timer, system tick.
// Optional timer (TH/TL/TCON/irq) is built only when DEVCTRL_TIMER_EN is defined.
module mmio_device_ctrl
    import devctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              wr_en,
    input  logic [31:0]       wdata,
    input  logic              rd_en,
    output logic [31:0]       rdata,
    output logic              irq,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic              w_hit;
    logic [OFF_W-1:0]  w_off;
    logic              w_wr_led;
    logic              w_wr_disp;
    logic [DATA_W-1:0] w_th_rd;
    logic [DATA_W-1:0] w_tl_rd;
    logic [DATA_W-1:0] w_tcon_rd;

    logic [LED_W-1:0]  r_led;
    logic [DISP_W-1:0] r_disp;
    logic [DATA_W-1:0] r_systick;
    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGI_W-1:0] r_digi;

    logic [DISP_W-1:0] w_disp_nxt;
    logic [3:0]        w_digit;
    logic [3:0]        w_anode;
    logic [6:0]        w_seg;

    logic              w_unused;

    // Window hit and word offset; byte lane bits are ignored
    assign w_hit     = (addr[31:OFF_W] == BASE_ADDR[31:OFF_W]);
    assign w_off     = {addr[OFF_W-1:2], 2'b00};
    assign w_wr_led  = wr_en & w_hit & (w_off == OFF_LED);
    assign w_wr_disp = wr_en & w_hit & (w_off == OFF_DISP);
    assign w_unused  = ^{addr[1:0], wdata};

    // LED register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led <= '0;
        end else if (w_wr_led) begin
            r_led <= wdata[LED_W-1:0];
        end
    end

    // Free-running system tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // Scan prescaler and digit index, independent of disp_en
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_MAX) begin
            r_pre <= '0;
            r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Display contents as they will be after this edge, so a store reaches digi without waiting for the scan
    assign w_disp_nxt = w_wr_disp ? wdata[DISP_W-1:0] : r_disp;

    // Select the nibble for the current digit
    always_comb begin
        w_digit = w_disp_nxt[3:0];
        case (r_idx)
            2'd0:    w_digit = w_disp_nxt[3:0];
            2'd1:    w_digit = w_disp_nxt[7:4];
            2'd2:    w_digit = w_disp_nxt[11:8];
            default: w_digit = w_disp_nxt[15:12];
        endcase
    end

    assign w_anode = ~(4'b0001 << r_idx);

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex   (w_digit),
        .o_seg_c (w_seg)
    );

    // DISP register and registered digit drive
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_disp <= '0;
            r_digi <= 12'hFFF;
        end else begin
            r_disp <= w_disp_nxt;
            if (w_disp_nxt[DISP_EN]) begin
                r_digi <= {w_anode, 1'b1, w_seg};
            end else begin
                r_digi <= 12'hFFF;
            end
        end
    end

    assign led  = r_led;
    assign digi = r_digi;

`ifdef DEVCTRL_TIMER_EN
    logic              w_wr_th;
    logic              w_wr_tl;
    logic              w_wr_tcon;
    logic [DATA_W-1:0] w_tl_nxt;
    logic              w_st_set;
    logic [DATA_W-1:0] r_th;
    logic [DATA_W-1:0] r_tl;
    logic              r_en;
    logic              r_ie;
    logic              r_st;
    logic              r_irq;

    assign w_wr_th   = wr_en & w_hit & (w_off == OFF_TH);
    assign w_wr_tl   = wr_en & w_hit & (w_off == OFF_TL);
    assign w_wr_tcon = wr_en & w_hit & (w_off == OFF_TCON);

    // Count/reload decision; a software store to TL overrides the hardware update
    always_comb begin
        w_tl_nxt = r_tl;
        w_st_set = 1'b0;
        if (r_en) begin
            if (r_tl == 32'hFFFF_FFFF) begin
                w_tl_nxt = r_th;
                w_st_set = r_ie;
            end else begin
                w_tl_nxt = r_tl + 32'd1;
            end
        end
        if (w_wr_tl) begin
            w_tl_nxt = wdata;
        end
    end

    // Timer registers; a hardware status set is never lost to a concurrent TCON store
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_th  <= '0;
            r_tl  <= '0;
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_st  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_tl  <= w_tl_nxt;
            r_irq <= r_ie & r_st;
            if (w_wr_th) begin
                r_th <= wdata;
            end
            if (w_wr_tcon) begin
                r_en <= wdata[TCON_EN];
                r_ie <= wdata[TCON_IE];
                r_st <= w_st_set | wdata[TCON_ST];
            end else begin
                r_st <= w_st_set | r_st;
            end
        end
    end

    assign w_th_rd   = r_th;
    assign w_tl_rd   = r_tl;
    assign w_tcon_rd = {29'd0, r_st, r_ie, r_en};
    assign irq       = r_irq;
`else
    assign w_th_rd   = '0;
    assign w_tl_rd   = '0;
    assign w_tcon_rd = '0;
    assign irq       = 1'b0;
`endif

    // Combinational load data mux
    always_comb begin
        rdata = '0;
        if (rd_en && w_hit) begin
            case (w_off)
                OFF_TH:      rdata = w_th_rd;
                OFF_TL:      rdata = w_tl_rd;
                OFF_TCON:    rdata = w_tcon_rd;
                OFF_LED:     rdata = {24'd0, r_led};
                OFF_DISP:    rdata = {15'd0, r_disp};
                OFF_SYSTICK: rdata = r_systick;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_device_ctrl.sv
// Directed bench for mmio_device_ctrl with SCAN_DIV = 4.
module tb_mmio_device_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] digi;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        bit          wr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        bit          rd;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t tbl [10];
    logic [16:0] pats [5] = '{17'h1_2A70, 17'h1_3210, 17'h1_7654, 17'h1_BA98, 17'h1_FEDC};

    mmio_device_ctrl #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wr_en (wr_en),
        .wdata (wdata),
        .rd_en (rd_en),
        .rdata (rdata),
        .irq   (irq),
        .led   (led),
        .digi  (digi)
    );

    always #5 clk = ~clk;

    // Edges since reset release: equals SYSTICK and fixes the scan phase
    always @(posedge clk) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1;
        d     = rdata;
        rd_en = 1'b0;
    endtask

    function automatic logic [11:0] exp_digi(input logic [16:0] d, input int kk);
        int         idx;
        logic [3:0] nib;
        logic [3:0] an;
        if (!d[16]) return 12'hFFF;
        idx = ((kk - 1) / 4) % 4;
        nib = 4'(d[15:0] >> (4 * idx));
        an  = ~(4'b0001 << idx);
        return {an, 1'b1, seg_tab[nib]};
    endfunction

    initial begin
        logic [31:0] d;

        tbl[0] = '{1'b1, BASE + 32'h0C, 32'h0000_00A5, 1'b1, BASE + 32'h0C, 32'h0000_00A5, 8'hA5};
        tbl[1] = '{1'b1, BASE + 32'h18, 32'h0000_DEAD, 1'b1, BASE + 32'h18, 32'h0,         8'hA5};
        tbl[2] = '{1'b1, 32'h5000_000C, 32'h0000_003C, 1'b1, 32'h5000_000C, 32'h0,         8'hA5};
        tbl[3] = '{1'b0, 32'h0,         32'h0,         1'b1, BASE + 32'h0C, 32'h0000_00A5, 8'hA5};
        tbl[4] = '{1'b1, BASE + 32'h0F, 32'hFFFF_FF5A, 1'b1, BASE + 32'h0C, 32'h0000_005A, 8'h5A};
        tbl[5] = '{1'b1, BASE + 32'h13, 32'h0001_2A70, 1'b1, BASE + 32'h10, 32'h0001_2A70, 8'h5A};
        tbl[6] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 1'b1, BASE + 32'h10, 32'h0001_FFFF, 8'h5A};
        tbl[7] = '{1'b0, 32'h0,         32'h0,         1'b0, BASE + 32'h0C, 32'h0,         8'h5A};
        tbl[8] = '{1'b1, BASE + 32'h1C, 32'h0000_0001, 1'b1, BASE + 32'h1C, 32'h0,         8'h5A};
        tbl[9] = '{1'b1, BASE + 32'h10, 32'h0000_0000, 1'b1, BASE + 32'h10, 32'h0,         8'h5A};

        // Reset held for two edges
        reset = 1'b0;
        tick();
        tick();
        chk("rst_led", {24'd0, led}, 32'h0);
        chk("rst_digi", {20'd0, digi}, 32'hFFF);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rd(BASE + 32'h14, d);
        chk("rst_systick", d, 32'h0);
        reset = 1'b1;
        repeat (5) tick();
        rd(BASE + 32'h14, d);
        chk("systick_5", d, 32'd5);

        // Register access table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) wr(tbl[i].waddr, tbl[i].wdat);
            addr  = tbl[i].raddr;
            rd_en = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
            rd_en = 1'b0;
        end

        // SYSTICK ignores stores and tracks cycles since reset
        wr(BASE + 32'h14, 32'hFFFF_0000);
        rd(BASE + 32'h14, d);
        chk("systick_ro", d, 32'(k));

`ifdef DEVCTRL_TIMER_EN
        wr(BASE + 32'h00, 32'hFFFF_FFFC);
        wr(BASE + 32'h04, 32'hFFFF_FFFC);
        wr(BASE + 32'h08, 32'h3);
        rd(BASE + 32'h04, d);  chk("tl_start", d, 32'hFFFF_FFFC);
        tick();
        rd(BASE + 32'h04, d);  chk("tl_inc", d, 32'hFFFF_FFFD);
        tick();
        tick();
        rd(BASE + 32'h04, d);  chk("tl_max", d, 32'hFFFF_FFFF);
        chk("irq_pre", {31'd0, irq}, 32'h0);
        tick();
        rd(BASE + 32'h04, d);  chk("tl_reload", d, 32'hFFFF_FFFC);
        rd(BASE + 32'h08, d);  chk("tcon_status", d, 32'h7);
        chk("irq_lag", {31'd0, irq}, 32'h0);
        tick();
        chk("irq_set", {31'd0, irq}, 32'h1);
        wr(BASE + 32'h08, 32'h3);
        rd(BASE + 32'h08, d);  chk("tcon_clear", d, 32'h3);
        wr(BASE + 32'h04, 32'hFFFF_FFFE);
        chk("irq_clear", {31'd0, irq}, 32'h0);
        rd(BASE + 32'h04, d);  chk("tl_store_fe", d, 32'hFFFF_FFFE);
        tick();
        rd(BASE + 32'h04, d);  chk("tl_ff2", d, 32'hFFFF_FFFF);
        wr(BASE + 32'h08, 32'h3);
        rd(BASE + 32'h08, d);  chk("tcon_race", d, 32'h7);
        rd(BASE + 32'h04, d);  chk("tl_race_reload", d, 32'hFFFF_FFFC);
        chk("irq_race_lag", {31'd0, irq}, 32'h0);
        tick();
        chk("irq_race", {31'd0, irq}, 32'h1);
        wr(BASE + 32'h04, 32'h5);
        rd(BASE + 32'h04, d);  chk("tl_store_wins", d, 32'h5);
        tick();
        rd(BASE + 32'h04, d);  chk("tl_after_store", d, 32'h6);
        wr(BASE + 32'h08, 32'h0);
        tick();
        chk("irq_off", {31'd0, irq}, 32'h0);
        rd(BASE + 32'h04, d);  chk("tl_hold", d, 32'h7);
`else
        wr(BASE + 32'h08, 32'h7);
        rd(BASE + 32'h08, d);  chk("tcon_absent", d, 32'h0);
        wr(BASE + 32'h00, 32'h1234_5678);
        rd(BASE + 32'h00, d);  chk("th_absent", d, 32'h0);
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        rd(BASE + 32'h04, d);  chk("tl_absent", d, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("irq_absent", {31'd0, irq}, 32'h0);
            tick();
        end
`endif

        // Display scan: four edges per digit, phase set by cycles since reset
        for (int p = 0; p < 5; p++) begin
            wr(BASE + 32'h10, {15'd0, pats[p]});
            for (int c = 0; c < 16; c++) begin
                chk($sformatf("digi_p%0d_c%0d", p, c), {20'd0, digi}, {20'd0, exp_digi(pats[p], k)});
                tick();
            end
        end
        wr(BASE + 32'h10, 32'h0000_2A70);
        for (int c = 0; c < 6; c++) begin
            chk("digi_off", {20'd0, digi}, 32'hFFF);
            tick();
        end
        wr(BASE + 32'h10, 32'h0001_2A70);
        for (int c = 0; c < 6; c++) begin
            chk("digi_reen", {20'd0, digi}, {20'd0, exp_digi(17'h1_2A70, k)});
            tick();
        end

        // Reset mid-scan clears everything at that edge
        wr(BASE + 32'h0C, 32'h0000_00C3);
        reset = 1'b0;
        tick();
        chk("mid_rst_digi", {20'd0, digi}, 32'hFFF);
        chk("mid_rst_led", {24'd0, led}, 32'h0);
        chk("mid_rst_irq", {31'd0, irq}, 32'h0);
        rd(BASE + 32'h10, d);  chk("mid_rst_disp", d, 32'h0);
        rd(BASE + 32'h14, d);  chk("mid_rst_systick", d, 32'h0);
`ifdef DEVCTRL_TIMER_EN
        rd(BASE + 32'h04, d);  chk("mid_rst_tl", d, 32'h0);
        rd(BASE + 32'h08, d);  chk("mid_rst_tcon", d, 32'h0);
`endif
        reset = 1'b1;
        wr(BASE + 32'h10, 32'h0001_3210);
        for (int c = 0; c < 8; c++) begin
            chk("post_rst_scan", {20'd0, digi}, {20'd0, exp_digi(17'h1_3210, k)});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
